// File: rtl/risc16_bus_io.sv
// risc16_bus_io -- memory-mapped I/O and bus steering for the risc16 core.
//
// Every core bus access is decoded. Addresses FFF0..FFFF (the I/O window)
// reach the on-block registers: GPIO out/in, a 16-bit timer with control,
// and a 4-entry byte transmit FIFO. All other addresses pass
// combinationally to external memory. The FIFO head is presented on a
// valid/ready byte stream toward a serial transmitter.
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   cpu_addr/wdata      core byte address and write data
//   cpu_oe/cpu_we       core read / write strobes
//   cpu_rdata           read data returned to the core (combinational)
//   mem_addr/wdata/oe/we, mem_rdata   external memory port
//   gpio_in/gpio_out    GPIO pins (gpio_in asynchronous)
//   tx_data/valid/ready byte stream to the serial transmitter
//
// Register map (select = cpu_addr[3:1], bit 0 ignored)
//   FFF0 GPIO_OUT R/W   FFF2 GPIO_IN R      FFF4 TIMER R/W
//   FFF6 TCTRL  b0 enable, b1 wrap (W1C)   FFF8 TXDATA W (push byte)
//   FFFA TXSTAT b0 full, b1 empty, b4:2 count, b5 overflow (W1C)
module risc16_bus_io (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  output logic [15:0] cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [11:0] IO_WINDOW = 12'hFFF;

  typedef enum logic [2:0] {
    REG_GPIO_OUT = 3'd0,
    REG_GPIO_IN  = 3'd1,
    REG_TIMER    = 3'd2,
    REG_TCTRL    = 3'd3,
    REG_TXDATA   = 3'd4,
    REG_TXSTAT   = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_sel_e;

  logic     io_hit;
  logic     io_wr;
  reg_sel_e reg_sel;

  // State
  logic [15:0] gpio_out_q, gpio_out_d;
  logic [15:0] sync1_q, sync2_q;
  logic [15:0] timer_q, timer_d;
  logic        enable_q, enable_d;
  logic        wrap_q, wrap_d;
  logic        overflow_q, overflow_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  fifo_mem_q [4];

  // FIFO control
  logic fifo_full, fifo_empty;
  logic push, pop, push_ok;

  logic [15:0] io_rdata;

  // Decode and pass-through
  assign io_hit    = (cpu_addr[15:4] == IO_WINDOW);
  assign io_wr     = cpu_we & io_hit;
  assign reg_sel   = reg_sel_e'(cpu_addr[3:1]);

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_oe    = cpu_oe & ~io_hit;
  assign mem_we    = cpu_we & ~io_hit;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  assign tx_valid   = ~fifo_empty;
  // Gate the head byte so tx_data is 0 whenever the FIFO holds nothing,
  // including straight out of reset.
  assign tx_data    = tx_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;

  // A push while full is only accepted when a pop frees the head slot in
  // the same cycle; otherwise it is dropped and flagged as overflow.
  assign push    = io_wr & (reg_sel == REG_TXDATA);
  assign pop     = tx_valid & tx_ready;
  assign push_ok = push & (~fifo_full | pop);

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    gpio_out_d = gpio_out_q;
    timer_d    = timer_q;
    enable_d   = enable_q;
    wrap_d     = wrap_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q + {1'b0, push_ok};
    rd_ptr_d   = rd_ptr_q + {1'b0, pop};
    count_d    = count_q + {2'b00, push_ok} - {2'b00, pop};

    if (io_wr && reg_sel == REG_GPIO_OUT) gpio_out_d = cpu_wdata;

    if (io_wr && reg_sel == REG_TCTRL) begin
      enable_d = cpu_wdata[0];
      if (cpu_wdata[1]) wrap_d = 1'b0;
    end

    // CPU write to TIMER overrides the increment. The wrap set is applied
    // after the clear above so it wins a same-cycle collision.
    if (io_wr && reg_sel == REG_TIMER) begin
      timer_d = cpu_wdata;
    end else if (enable_q) begin
      timer_d = timer_q + 16'd1;
      if (timer_q == 16'hFFFF) wrap_d = 1'b1;
    end

    if (io_wr && reg_sel == REG_TXSTAT && cpu_wdata[5]) overflow_d = 1'b0;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  // Register file
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      timer_q    <= '0;
      enable_q   <= 1'b0;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      timer_q    <= timer_d;
      enable_q   <= enable_d;
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; resetting the count
  // and pointers discards its contents, and tx_data is gated while empty.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= cpu_wdata[7:0];
  end

  assign gpio_out = gpio_out_q;

  // Read path (combinational, not gated by cpu_oe)
  always_comb begin
    io_rdata = 16'h0000;
    case (reg_sel)
      REG_GPIO_OUT: io_rdata = gpio_out_q;
      REG_GPIO_IN:  io_rdata = sync2_q;
      REG_TIMER:    io_rdata = timer_q;
      REG_TCTRL:    io_rdata = {14'h0, wrap_q, enable_q};
      REG_TXSTAT:   io_rdata = {10'h0, overflow_q, count_q, fifo_empty, fifo_full};
      default:      io_rdata = 16'h0000;
    endcase
  end

  assign cpu_rdata = io_hit ? io_rdata : mem_rdata;

endmodule

// File: tb/tb_risc16_bus_io.sv
// Testbench for risc16_bus_io: directed stimulus, a queue-based behavioural
// model checked on every falling edge, plus literal expectations.
module tb_risc16_bus_io;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, cpu_wdata, mem_rdata, gpio_in;
  logic        cpu_oe, cpu_we, tx_ready;
  logic [15:0] cpu_rdata, mem_addr, mem_wdata, gpio_out;
  logic        mem_oe, mem_we, tx_valid;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;

  risc16_bus_io dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we),
    .gpio_in(gpio_in), .gpio_out(gpio_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_gpio, m_timer, m_s1, m_s2;
  logic        m_en, m_wrap, m_ovf;
  logic [7:0]  m_q[$];

  function automatic logic [15:0] m_txstat();
    int n = m_q.size();
    return {10'h0, m_ovf, 3'(n), n == 0, n == 4};
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a[15:4] != 12'hFFF) return mem_rdata;
    case (a[3:1])
      3'd0: return m_gpio;
      3'd1: return m_s2;
      3'd2: return m_timer;
      3'd3: return {14'h0, m_wrap, m_en};
      3'd5: return m_txstat();
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_gpio = 0; m_timer = 0; m_s1 = 0; m_s2 = 0;
      m_en = 0; m_wrap = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      bit wr, popping, full_before, wrap_ev;
      logic [2:0] idx;
      wr = cpu_we && (cpu_addr[15:4] == 12'hFFF);
      idx = cpu_addr[3:1];
      popping = (m_q.size() > 0) && tx_ready;
      full_before = (m_q.size() == 4);
      wrap_ev = 0;
      m_s2 = m_s1;
      m_s1 = gpio_in;
      if (wr && idx == 3'd2) m_timer = cpu_wdata;
      else if (m_en) begin
        wrap_ev = (m_timer == 16'hFFFF);
        m_timer = m_timer + 16'd1;
      end
      if (wr && idx == 3'd3) begin
        m_en = cpu_wdata[0];
        if (cpu_wdata[1]) m_wrap = 0;
      end
      if (wrap_ev) m_wrap = 1;
      if (wr && idx == 3'd0) m_gpio = cpu_wdata;
      if (wr && idx == 3'd5 && cpu_wdata[5]) m_ovf = 0;
      if (popping) void'(m_q.pop_front());
      if (wr && idx == 3'd4) begin
        if (full_before && !popping) m_ovf = 1;
        else m_q.push_back(cpu_wdata[7:0]);
      end
    end
  end

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      bit hit;
      hit = (cpu_addr[15:4] == 12'hFFF);
      check("cmp_rdata",    cpu_rdata, m_read(cpu_addr));
      check("cmp_mem_addr", mem_addr, cpu_addr);
      check("cmp_mem_wdata", mem_wdata, cpu_wdata);
      check("cmp_mem_oe",   {15'h0, mem_oe}, {15'h0, cpu_oe & ~hit});
      check("cmp_mem_we",   {15'h0, mem_we}, {15'h0, cpu_we & ~hit});
      check("cmp_gpio_out", gpio_out, m_gpio);
      check("cmp_tx_valid", {15'h0, tx_valid}, {15'h0, m_q.size() != 0});
      check("cmp_tx_data",  {8'h0, tx_data}, {8'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1; cpu_oe = 0;
    step();
    cpu_we = 0;
  endtask

  task automatic rd_lit(input string name, input logic [15:0] a, input logic [15:0] exp);
    cpu_addr = a; cpu_we = 0; cpu_oe = 1;
    #1;
    check(name, cpu_rdata, exp);
    cpu_oe = 0;
  endtask

  task automatic drain_lit(input string name, input logic [7:0] exp[4]);
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check({name, "_valid"}, {15'h0, tx_valid}, 16'h0001);
      check({name, "_data"}, {8'h0, tx_data}, {8'h0, exp[i]});
      step();
    end
    check({name, "_empty"}, {15'h0, tx_valid}, 16'h0000);
    tx_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp1[4];
    logic [7:0] exp2[4];
    rst = 0; cpu_addr = 0; cpu_wdata = 0; cpu_oe = 0; cpu_we = 0;
    mem_rdata = 16'hC0DE; gpio_in = 0; tx_ready = 0;
    #12;
    check("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
    check("rst_gpio_out", gpio_out, 16'h0000);
    check("rst_tx_data", {8'h0, tx_data}, 16'h0000);
    step();
    rst = 1;
    step();

    // Reset register values
    rd_lit("rst_gpio", 16'hFFF0, 16'h0000);
    rd_lit("rst_timer", 16'hFFF4, 16'h0000);
    rd_lit("rst_txstat", 16'hFFFA, 16'h0002);
    rd_lit("mem_read", 16'h0100, 16'hC0DE);

    // GPIO out and memory pass-through
    cpu_addr = 16'hFFF0; cpu_wdata = 16'hA5C3; cpu_we = 1; #1;
    check("io_we_supp", {15'h0, mem_we}, 16'h0000);
    step(); cpu_we = 0;
    check("gpio_out_a5c3", gpio_out, 16'hA5C3);
    rd_lit("gpio_rd_bit0", 16'hFFF1, 16'hA5C3);
    cpu_addr = 16'h0100; cpu_wdata = 16'h1234; cpu_we = 1; #1;
    check("mem_we_on", {15'h0, mem_we}, 16'h0001);
    check("mem_addr", mem_addr, 16'h0100);
    step(); cpu_we = 0;
    rd_lit("rsvd_rd", 16'hFFFC, 16'h0000);
    wr(16'hFFFE, 16'hFFFF);
    rd_lit("txdata_rd", 16'hFFF8, 16'h0000);

    // GPIO input synchronizer: two edges of latency
    gpio_in = 16'hBEEF;
    rd_lit("sync_0", 16'hFFF2, 16'h0000);
    step();
    rd_lit("sync_1", 16'hFFF2, 16'h0000);
    step();
    rd_lit("sync_2", 16'hFFF2, 16'hBEEF);

    // Timer wrap, sticky flag, W1C
    wr(16'hFFF4, 16'hFFFE);
    wr(16'hFFF6, 16'h0001);
    step(); step();
    rd_lit("timer_wrap", 16'hFFF4, 16'h0000);
    rd_lit("tctrl_wrap", 16'hFFF6, 16'h0003);
    wr(16'hFFF6, 16'h0003);
    rd_lit("tctrl_clr", 16'hFFF6, 16'h0001);
    rd_lit("timer_run", 16'hFFF4, 16'h0001);
    wr(16'hFFF6, 16'h0000);

    // FIFO overflow
    tx_ready = 0;
    wr(16'hFFF8, 16'h0011); wr(16'hFFF8, 16'h0022);
    wr(16'hFFF8, 16'h0033); wr(16'hFFF8, 16'h0044);
    wr(16'hFFF8, 16'h0055);
    rd_lit("txstat_ovf", 16'hFFFA, 16'h0031);
    exp1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain_lit("drain1", exp1);
    rd_lit("txstat_empty_ovf", 16'hFFFA, 16'h0022);
    wr(16'hFFFA, 16'h0020);
    rd_lit("txstat_ovf_clr", 16'hFFFA, 16'h0002);

    // Push while empty with tx_ready=1: stored, not popped
    tx_ready = 1;
    wr(16'hFFF8, 16'h0077);
    tx_ready = 0;
    rd_lit("push_empty_rdy", 16'hFFFA, 16'h0004);
    tx_ready = 1; step(); tx_ready = 0;

    // Full FIFO, simultaneous push and pop
    wr(16'hFFF8, 16'h00AA); wr(16'hFFF8, 16'h00BB);
    wr(16'hFFF8, 16'h00CC); wr(16'hFFF8, 16'h00DD);
    tx_ready = 1;
    wr(16'hFFF8, 16'h0066);
    tx_ready = 0;
    rd_lit("full_push_pop", 16'hFFFA, 16'h0011);
    exp2 = '{8'hBB, 8'hCC, 8'hDD, 8'h66};
    drain_lit("drain2", exp2);

    // Reset mid-stream with three bytes queued and a push in flight
    wr(16'hFFF8, 16'h0001); wr(16'hFFF8, 16'h0002); wr(16'hFFF8, 16'h0003);
    #1;
    check("pre_rst_valid", {15'h0, tx_valid}, 16'h0001);
    cpu_addr = 16'hFFF8; cpu_wdata = 16'h0004; cpu_we = 1;
    #1;
    rst = 0;
    #1;
    check("async_rst_valid", {15'h0, tx_valid}, 16'h0000);
    check("async_rst_gpio", gpio_out, 16'h0000);
    step();
    cpu_we = 0;
    step();
    rst = 1;
    step();
    rd_lit("post_rst_txstat", 16'hFFFA, 16'h0002);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
